fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 SHALL have parameter PC_W, default 64, program counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream fetch presents an entry.
REQ-006 SHALL have port in_ready  output  1  queue can accept an entry this cycle.
REQ-007 SHALL have port in_pc  input  PC_W  PC of the fetched instruction.
REQ-008 SHALL have port in_instr  input  32  fetched instruction word.
REQ-009 SHALL have port out_valid  output  1  head entry is valid for the IF/ID register.
REQ-010 SHALL have port out_ready  input  1  IF/ID write enable; consumer takes the head entry.
REQ-011 SHALL have port out_pc  output  PC_W  PC of the head entry.
REQ-012 SHALL have port out_instr  output  32  instruction of the head entry.
REQ-013 SHALL have port flush  input  1  branch redirect; discard all queued entries.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 SHALL push when in_valid && in_ready, writing {in_pc, in_instr} at the tail and advancing the tail pointer.
REQ-016 SHALL pop when out_valid && out_ready, advancing the head pointer.
REQ-017 SHALL drive in_ready = (count < DEPTH); at full, in_ready SHALL be 0 even if a pop occurs that cycle.
REQ-018 SHALL drive out_valid = (count != 0), with out_pc/out_instr read combinationally from the head entry.
REQ-019 SHALL drive out_instr = 32'h00000013 (NOP) and out_pc = 0 whenever out_valid = 0.
REQ-020 SHALL keep count unchanged on a simultaneous push and pop, and update it by +1/-1 for push-only/pop-only.
REQ-021 SHALL wrap head and tail pointers modulo DEPTH.
REQ-022 SHALL give a pushed entry one-cycle latency: pushed at edge N, visible at out_* after edge N.
REQ-023 SHALL give flush priority over push and pop: at the next edge count, head and tail become 0, and any entry offered that cycle is discarded.
REQ-024 SHALL keep out_* stable while out_valid = 1 and out_ready = 0, with no flush.

Reset
REQ-025 SHALL set count, head and tail to 0 on reset; out_valid and in_ready SHALL then read 0 and 1.
REQ-026 SHALL give reset priority over flush, push and pop; storage contents need not be reset.

Configuration
REQ-027 SHALL, with FETCH_QUEUE_BYPASS_EN defined, present in_pc/in_instr on out_* with out_valid = 1 in the same cycle when count = 0, in_valid = 1 and flush = 0; if out_ready = 1 that entry SHALL NOT be written.
REQ-028 SHALL, without FETCH_QUEUE_BYPASS_EN, behave exactly as REQ-018/REQ-022, with no combinational path from in_* to out_*.

Structure
REQ-029 SHALL take the NOP encoding (32'h00000013) and the instruction width (32) from shared package core_pkg, alongside the existing pipeline constants.
REQ-030 SHALL implement pointer/count logic in one sub-module, fq_ptr_ctrl, with storage and output muxing in fetch_queue.

Verification
REQ-031 SHALL check reset: after reset, count=0, out_valid=0, in_ready=1 and out_instr=32'h00000013.
REQ-032 SHALL check fill and drain: push 4 entries (pc 0,4,8,12) with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> pcs pop in order 0,4,8,12 over 4 cycles.
REQ-033 SHALL check full with simultaneous events: at count=4, in_valid=1 and out_ready=1 -> pop occurs, push is rejected, count=3.
REQ-034 SHALL check wrap: 10 push/pop pairs at count=2 -> FIFO order is preserved across the pointer wrap and count stays 2.
REQ-035 SHALL check flush: at count=3, flush=1 with in_valid=1 -> count=0 next cycle, the offered entry is discarded, and the next push of pc 0x40 is the first entry popped.
REQ-036 SHALL check bypass: with FETCH_QUEUE_BYPASS_EN, count=0, in_valid=1, in_pc=0x80 and out_ready=1 -> out_pc=0x80 in the same cycle and count stays 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline constants for the core front end.
// Consumed by fetch_queue for the instruction width and the NOP bubble encoding.
package core_pkg;

    localparam int                   XLEN       = 64;
    localparam int                   INSTR_W    = 32;
    localparam logic [INSTR_W-1:0]   NOP_INSTR  = 32'h0000_0013;
    localparam logic [XLEN-1:0]      RESET_PC   = '0;

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Head/tail pointer and occupancy tracking for fetch_queue.
// Reset and flush both clear the pointers; push and pop are pre-qualified by the caller.
module fq_ptr_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH)-1:0]   o_head,
    output logic [$clog2(DEPTH)-1:0]   o_tail,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_not_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + AW'(1);
            if (i_pop)  r_head <= r_head + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head     = r_head;
    assign o_tail     = r_tail;
    assign o_count    = r_count;
    assign o_not_full = (r_count < CW'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and the IF/ID register; emits NOP bubbles when empty.
// Define FETCH_QUEUE_BYPASS_EN to let an entry offered to an empty queue reach out_* in the same cycle.
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];

    logic [AW-1:0]      w_head;
    logic [AW-1:0]      w_tail;
    logic               w_not_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_bypass_take;

    assign w_empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;
    assign w_bypass      = w_empty && in_valid && !flush;
    assign w_bypass_take = w_bypass && out_ready;
`else
    assign w_bypass_take = 1'b0;
`endif

    // A bypassed entry consumed this cycle never lands in storage.
    assign w_push = in_valid && w_not_full && !flush && !w_bypass_take;
    assign w_pop  = !w_empty && out_ready && !flush;

    fq_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (flush),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_tail     (w_tail),
        .o_count    (count),
        .o_not_full (w_not_full)
    );

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[w_tail]    <= in_pc;
            r_instr_mem[w_tail] <= in_instr;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (!w_empty) begin
            out_valid = 1'b1;
            out_pc    = r_pc_mem[w_head];
            out_instr = r_instr_mem[w_head];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (w_bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`endif
    end

    assign in_ready = w_not_full;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue model predicts count, handshakes and head entry each cycle.
// Build with FETCH_QUEUE_BYPASS_EN defined to also exercise the same-cycle bypass path.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            flush;
    logic [2:0]      count;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .flush     (flush),
        .count     (count)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'hA000_0000 ^ pc[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = rdy;
        flush     = fl;
    endtask

    // Check the current cycle against the model, then advance model and DUT by one edge.
    task automatic step();
        bit   empty;
        bit   full;
        bit   byp;
        ent_t e;
        @(negedge clk);
        empty = (sb.size() == 0);
        full  = (sb.size() >= DEPTH);
        byp   = BYP && empty && in_valid && !flush;
        check("count", 64'(count), 64'(sb.size()));
        check("in_ready", 64'(in_ready), 64'(!full));
        if (!empty) begin
            check("out_valid", 64'(out_valid), 64'd1);
            check("out_pc", out_pc, sb[0].pc);
            check("out_instr", 64'(out_instr), 64'(sb[0].instr));
        end else if (byp) begin
            check("byp_valid", 64'(out_valid), 64'd1);
            check("byp_pc", out_pc, in_pc);
            check("byp_instr", 64'(out_instr), 64'(in_instr));
        end else begin
            check("out_valid", 64'(out_valid), 64'd0);
            check("out_pc_idle", out_pc, 64'd0);
            check("out_instr_nop", 64'(out_instr), 64'(NOP));
        end
        if (reset || flush) begin
            sb.delete();
        end else if (!(byp && out_ready)) begin
            if (out_ready && !empty) void'(sb.pop_front());
            if (in_valid && !full) begin
                e.pc    = in_pc;
                e.instr = in_instr;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // fill to full with the consumer stalled, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(i * 4), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        repeat (4) step();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        step();

        // full with simultaneous offer and pop: push must be refused
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h100 + 64'(i * 4), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 64'h110, 1'b1, 1'b0);
        step();
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        repeat (3) step();
        step();

        // steady push/pop at count 2 across several pointer wraps
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h200 + 64'(i * 4), 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h208 + 64'(i * 4), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        repeat (3) step();

        // flush discards queued entries and the entry offered alongside it
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h300 + 64'(i * 4), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 64'h399, 1'b0, 1'b1);
        step();
        drive(1'b1, 64'h40, 1'b0, 1'b0);
        step();
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        repeat (2) step();

        // reset wins over flush, push and pop
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h500 + 64'(i * 4), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 64'h508, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        step();

`ifdef FETCH_QUEUE_BYPASS_EN
        drive(1'b1, 64'h80, 1'b1, 1'b0);
        step();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 64'h84, 1'b0, 1'b0);
        step();
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        repeat (2) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
